// File: rtl/vx_mem_responder.sv
// Memory-side responder for the Vortex external memory bus: byte-enabled line store,
// fixed-latency read pipeline and an in-order response FIFO guarded by read credits.
module vx_mem_responder #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned MEM_LINES      = 1024,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned RSP_QUEUE_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LW    = $clog2(MEM_LINES);
  localparam int unsigned QW    = $clog2(RSP_QUEUE_SIZE);
  localparam int unsigned CW    = QW + 1;

  logic [DATA_WIDTH-1:0] store [MEM_LINES];
  logic [LW-1:0]         line;
  logic                  req_fire, rd_fire, wr_fire, rsp_fire;
  logic [CW-1:0]         outstanding;

  logic                  pipe_valid [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data  [LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag   [LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_QUEUE_SIZE];
  logic [QW:0]           wr_ptr, rd_ptr;
  logic                  fifo_push, fifo_empty, fifo_full;

  logic unused_addr;
  assign unused_addr = ^mem_req_addr[ADDR_WIDTH-1:LW];

  assign line = mem_req_addr[LW-1:0];

  // Ready depends only on registered credit state; requests are never taken during reset.
  assign mem_req_ready = reset || (outstanding != CW'(RSP_QUEUE_SIZE));
  assign req_fire      = mem_req_valid && mem_req_ready && !reset;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (mem_req_byteen[b]) store[line][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_valid[i] <= 1'b0;
    end else begin
      pipe_valid[0] <= rd_fire;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[0] <= store[line];
    pipe_tag[0]  <= mem_req_tag;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_tag[i]  <= pipe_tag[i-1];
    end
  end

  // Credits bound pipeline plus FIFO occupancy, so the pipeline exit can push unconditionally.
  assign fifo_push  = pipe_valid[LATENCY-1];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[QW] != rd_ptr[QW]) && (wr_ptr[QW-1:0] == rd_ptr[QW-1:0]);

  assign mem_rsp_valid = !fifo_empty && !reset;
  assign mem_rsp_data  = fifo_data[rd_ptr[QW-1:0]];
  assign mem_rsp_tag   = fifo_tag[rd_ptr[QW-1:0]];
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr[QW-1:0]] <= pipe_data[LATENCY-1];
      fifo_tag[wr_ptr[QW-1:0]]  <= pipe_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + (QW+1)'(1);
      if (rsp_fire)  rd_ptr <= rd_ptr + (QW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign busy = !reset && (outstanding != '0);

`ifndef SYNTHESIS
  a_fifo_overflow: assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));
  a_credit_underflow: assert property (@(posedge clk) disable iff (reset)
    !(rsp_fire && !rd_fire && outstanding == '0));
  a_byteen_known: assert property (@(posedge clk) disable iff (reset)
    wr_fire |-> !$isunknown(mem_req_byteen));
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder: vector table plus backpressure, credit and reset sequences.
module tb_vx_mem_responder;

  localparam int DW  = 512;
  localparam int AW  = 26;
  localparam int TW  = 8;
  localparam int BW  = DW / 8;
  localparam int LAT = 4;
  localparam int QS  = 8;

  logic          clk, reset;
  logic          mem_req_valid, mem_req_rw, mem_req_ready;
  logic [BW-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_rsp_valid, mem_rsp_ready, busy;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;

  vx_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .MEM_LINES(1024), .LATENCY(LAT), .RSP_QUEUE_SIZE(QS)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            fire_edge;
  } exp_t;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [TW-1:0] tag;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   tests = 0, fails = 0;
  int   rsp_count = 0, min_lat = 1000, max_lat = 0;

  localparam logic [DW-1:0] ALL_A5 = {64{8'hA5}};
  localparam logic [DW-1:0] PART   = {{60{8'h00}}, {4{8'hFF}}};
  localparam logic [DW-1:0] HALF   = {{32{8'h5A}}, {32{8'hA5}}};
  localparam logic [DW-1:0] PAT_P  = {16{32'h1234_5678}};
  localparam logic [DW-1:0] PAT_Q  = {8{64'h0F1E_2D3C_4B5A_6978}};
  localparam logic [BW-1:0] BE_ALL = {BW{1'b1}};

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic checkn(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic void expect_rd(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    exp_t e;
    e.tag = tag;
    e.data = data;
    e.fire_edge = cyc + 1;
    sb.push_back(e);
  endfunction

  exp_t mon_e;
  int   mon_lat;
  always @(negedge clk) begin
    if (!reset && mem_rsp_valid === 1'b1 && mem_rsp_ready) begin
      rsp_count++;
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got tag %0d required no response", mem_rsp_tag);
      end else begin
        mon_e = sb.pop_front();
        checkn("rsp_tag", int'(mem_rsp_tag), int'(mon_e.tag));
        check("rsp_data", mem_rsp_data, mon_e.data);
        mon_lat = cyc - mon_e.fire_edge;
        if (mon_lat < min_lat) min_lat = mon_lat;
        if (mon_lat > max_lat) max_lat = mon_lat;
      end
    end
  end

  task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [BW-1:0] be, input logic [TW-1:0] tag, input logic [DW-1:0] exp);
    bit done = 0;
    int budget = 50;
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = addr;
    mem_req_data = data; mem_req_byteen = be; mem_req_tag = tag;
    while (!done) begin
      @(negedge clk);
      if (mem_req_ready) begin
        if (!rw) expect_rd(tag, exp);
        done = 1;
      end else if (--budget == 0) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got ready 0 required 1 for tag %0d", tag);
        done = 1;
      end
      @(posedge clk); #1;
    end
    mem_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkn("drain_pending", sb.size() + int'(busy), 0);
  endtask

  task automatic burst_reads(input logic [AW-1:0] addr, input logic [TW-1:0] first_tag,
                             input int max_n, input int cycles, input logic [DW-1:0] exp,
                             output int accepted);
    accepted = 0;
    for (int c = 0; c < cycles; c++) begin
      mem_req_valid = (accepted < max_n);
      mem_req_rw = 1'b0; mem_req_addr = addr; mem_req_byteen = '0;
      mem_req_tag = first_tag + TW'(accepted);
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        expect_rd(mem_req_tag, exp);
        accepted++;
      end
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[12];
  int   acc;

  initial begin
    vecs[0]  = '{1'b1, 26'h10,  ALL_A5,         BE_ALL,                      8'h03, '0};
    vecs[1]  = '{1'b0, 26'h10,  '0,             '0,                          8'h07, ALL_A5};
    vecs[2]  = '{1'b1, 26'h20,  '0,             BE_ALL,                      8'h00, '0};
    vecs[3]  = '{1'b1, 26'h20,  {64{8'hFF}},    64'h0000_0000_0000_000F,     8'h00, '0};
    vecs[4]  = '{1'b0, 26'h20,  '0,             '0,                          8'h08, PART};
    vecs[5]  = '{1'b1, 26'h5,   PAT_P,          BE_ALL,                      8'h01, '0};
    vecs[6]  = '{1'b0, 26'h405, '0,             '0,                          8'h09, PAT_P};
    vecs[7]  = '{1'b1, 26'h10,  {64{8'h5A}},    {{32{1'b1}}, {32{1'b0}}},    8'h02, '0};
    vecs[8]  = '{1'b0, 26'h10,  '0,             '0,                          8'h42, HALF};
    vecs[9]  = '{1'b0, 26'h5,   '0,             '0,                          8'hFF, PAT_P};
    vecs[10] = '{1'b1, 26'h3FF, PAT_Q,          BE_ALL,                      8'h04, '0};
    vecs[11] = '{1'b0, 26'h7FF, '0,             '0,                          8'h10, PAT_Q};

    reset = 1'b1; mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_byteen = '0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkn("in_reset_ready", int'(mem_req_ready), 1);
    checkn("in_reset_rsp_valid", int'(mem_rsp_valid), 0);
    checkn("in_reset_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkn("post_reset_ready", int'(mem_req_ready), 1);
    checkn("post_reset_rsp_valid", int'(mem_rsp_valid), 0);
    checkn("post_reset_busy", int'(busy), 0);
    @(posedge clk); #1;

    // Vector table, back-to-back with the consumer always ready.
    rsp_count = 0;
    for (int i = 0; i < 12; i++)
      send(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].tag, vecs[i].exp);
    drain();
    checkn("table_rsp_count", rsp_count, 6);
    checkn("min_latency", min_lat, LAT);
    checkn("max_latency", max_lat, LAT);

    // Backpressure: only QS reads accepted while the consumer stalls.
    mem_rsp_ready = 1'b0;
    burst_reads(26'h10, 8'd0, 10, 14, HALF, acc);
    checkn("bp_accepted", acc, QS);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'h10; mem_req_tag = 8'd8;
    @(negedge clk);
    checkn("bp_ready_low", int'(mem_req_ready), 0);
    checkn("bp_busy", int'(busy), 1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkn("bp_head_tag", int'(mem_rsp_tag), 0);
      check("bp_head_data", mem_rsp_data, HALF);
    end
    @(posedge clk); #1;
    pop_cyc.delete();
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    checkn("full_rsp_fire_no_accept", int'(mem_req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkn("ready_after_rsp_fire", int'(mem_req_ready), 1);
    if (mem_req_ready) expect_rd(8'd8, HALF);
    @(posedge clk); #1;
    mem_req_tag = 8'd9;
    @(negedge clk);
    checkn("bp_tag9_ready", int'(mem_req_ready), 1);
    if (mem_req_ready) expect_rd(8'd9, HALF);
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    drain();
    checkn("bp_rsp_count", pop_cyc.size(), 10);
    if (pop_cyc.size() >= 8) checkn("bp_back_to_back", pop_cyc[7] - pop_cyc[0], 7);

    // Read fire and response fire in one cycle leave the credit count at 3.
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 26'h405, '0, '0, 8'h20 + 8'(i), PAT_P);
    repeat (LAT + 2) @(posedge clk);
    #1;
    mem_rsp_ready = 1'b1;
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'h405; mem_req_tag = 8'h23;
    @(negedge clk);
    checkn("sim_req_ready", int'(mem_req_ready), 1);
    checkn("sim_rsp_valid", int'(mem_rsp_valid), 1);
    if (mem_req_ready) expect_rd(8'h23, PAT_P);
    @(posedge clk); #1;
    mem_rsp_ready = 1'b0;
    burst_reads(26'h405, 8'h24, 8, 10, PAT_P, acc);
    checkn("sim_credit_left", acc, QS - 3);
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b1;
    drain();

    // Reset with reads in flight drops them but keeps the store.
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 26'h7FF, '0, '0, 8'h30 + 8'(i), PAT_Q);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkn("midrst_rsp_valid", int'(mem_rsp_valid), 0);
    checkn("midrst_busy", int'(busy), 0);
    checkn("midrst_ready", int'(mem_req_ready), 1);
    @(posedge clk); #1;
    mem_rsp_ready = 1'b1;
    acc = rsp_count;
    repeat (LAT + 4) @(posedge clk);
    #1;
    checkn("midrst_no_rsp", rsp_count - acc, 0);
    send(1'b0, 26'h20, '0, '0, 8'h44, PART);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
